// File: rtl/io_delay_ctrl_pkg.sv
// Shared types and constants for the IO delay tap sequencer.
// Holds the FSM state enum, the command opcodes and the default channel/tap sizes.
package io_delay_ctrl_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int TAP_W_DEF  = 5;

  localparam logic [1:0] OP_LOAD_ONE = 2'd0;
  localparam logic [1:0] OP_LOAD_ALL = 2'd1;
  localparam logic [1:0] OP_SWEEP    = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DWELL  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/io_delay_dwell_timer.sv
// Loadable down-counter shared by the SETTLE and DWELL waits.
// Loading N-1 makes o_expire assert on the Nth cycle after the load.
module io_delay_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_cnt;
  logic               r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = r_run && (r_cnt == '0);

endmodule

// File: rtl/io_delay_tap_ctrl.sv
// Tap load / tap sweep sequencer for the IO delay channels; all outputs registered.
// Define IO_DLY_CTRL_VERIFY_EN to compile in the docnt readback compare (VERIFY state).
module io_delay_tap_ctrl
  import io_delay_ctrl_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int TAP_W      = TAP_W_DEF,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [1:0]                cmd_ch,
  input  logic [TAP_W-1:0]          cmd_tap,
  input  logic [DWELL_W-1:0]        cmd_dwell,
  input  logic                      sample_in,
  output logic [NUM_CH-1:0]         ldcnt,
  output logic [NUM_CH*TAP_W-1:0]   dicnt,
  input  logic [NUM_CH*TAP_W-1:0]   docnt,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      edge_found,
  output logic [TAP_W-1:0]          edge_tap
);

  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  state_e                    r_state, w_state_nxt;
  logic [1:0]                r_op;
  logic [TAP_W-1:0]          r_tap, w_tap_nxt, r_edge_tap;
  logic [DWELL_W-1:0]        r_dwell, w_tmr_val;
  logic [NUM_CH-1:0]         r_ldmask, w_mask, r_ldcnt, w_ldcnt_nxt;
  logic [NUM_CH*TAP_W-1:0]   r_dicnt;
  logic                      r_busy, r_done, r_err, r_edge_found, r_ready;
  logic                      w_accept, w_tmr_load, w_expire, w_mismatch;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;

  io_delay_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_state_nxt = (cmd_op == OP_RSVD) ? ST_DONE : ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_SETTLE;
`ifdef IO_DLY_CTRL_VERIFY_EN
      ST_SETTLE: if (w_expire) w_state_nxt = ST_VERIFY;
      ST_VERIFY: w_state_nxt = (r_op == OP_SWEEP) ? ST_DWELL : ST_DONE;
`else
      ST_SETTLE: if (w_expire) w_state_nxt = (r_op == OP_SWEEP) ? ST_DWELL : ST_DONE;
`endif
      ST_DWELL:  if (w_expire) w_state_nxt = ST_NEXT;
      ST_NEXT:   w_state_nxt = (r_tap == TAP_MAX || r_edge_found) ? ST_DONE : ST_LOAD;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // r_tap doubles as the sweep index; it is what gets driven onto dicnt in LOAD.
  always_comb begin
    w_mask = r_ldmask;
    if (r_state == ST_IDLE)
      w_mask = (cmd_op == OP_LOAD_ONE) ? (NUM_CH'(1) << cmd_ch) : '1;
    w_tap_nxt = r_tap;
    if (w_accept)
      w_tap_nxt = (cmd_op == OP_SWEEP) ? '0 : cmd_tap;
    else if (r_state == ST_NEXT && w_state_nxt == ST_LOAD)
      w_tap_nxt = r_tap + 1'b1;
    w_ldcnt_nxt = (w_state_nxt == ST_LOAD) ? w_mask : '0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = DWELL_W'(SETTLE_CYC - 1);
    if (r_state == ST_LOAD) begin
      w_tmr_load = 1'b1;
    end else if (w_state_nxt == ST_DWELL && r_state != ST_DWELL) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
    end
  end

`ifdef IO_DLY_CTRL_VERIFY_EN
  always_comb begin
    w_mismatch = 1'b0;
    for (int n = 0; n < NUM_CH; n++)
      if (r_ldmask[n] && docnt[n*TAP_W +: TAP_W] != r_dicnt[n*TAP_W +: TAP_W])
        w_mismatch = 1'b1;
  end
`else
  logic w_unused_docnt;
  assign w_unused_docnt = ^docnt;
  assign w_mismatch     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= OP_LOAD_ONE;
      r_tap        <= '0;
      r_dwell      <= '0;
      r_ldmask     <= '0;
      r_ldcnt      <= '0;
      r_dicnt      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_edge_found <= 1'b0;
      r_edge_tap   <= '0;
      r_ready      <= 1'b1;
    end else begin
      r_ldcnt <= w_ldcnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
      r_ready <= (w_state_nxt == ST_IDLE);
      r_tap   <= w_tap_nxt;
      if (w_accept) begin
        r_op         <= cmd_op;
        r_ldmask     <= w_mask;
        r_dwell      <= cmd_dwell;
        r_err        <= (cmd_op == OP_RSVD);
        r_edge_found <= 1'b0;
        r_edge_tap   <= '0;
      end
      if (w_state_nxt == ST_LOAD)
        for (int n = 0; n < NUM_CH; n++)
          if (w_mask[n]) r_dicnt[n*TAP_W +: TAP_W] <= w_tap_nxt;
      if (r_state == ST_VERIFY && w_mismatch)
        r_err <= 1'b1;
      if (r_state == ST_DWELL && w_expire && sample_in && !r_edge_found) begin
        r_edge_found <= 1'b1;
        r_edge_tap   <= r_tap;
      end
    end
  end

  assign cmd_ready  = r_ready;
  assign ldcnt      = r_ldcnt;
  assign dicnt      = r_dicnt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign edge_found = r_edge_found;
  assign edge_tap   = r_edge_tap;

endmodule

// File: tb/tb_io_delay_tap_ctrl.sv
// Scoreboard bench for io_delay_tap_ctrl: directed scenarios plus random commands.
// Expected results come from a command-level model; a negedge monitor checks each done.
module tb_io_delay_tap_ctrl;
  import io_delay_ctrl_pkg::*;

  localparam int NCH = 4;
  localparam int TW  = 5;
  localparam int DW  = 16;
  localparam int S   = 2;
`ifdef IO_DLY_CTRL_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [1:0]        cmd_ch = '0;
  logic [TW-1:0]     cmd_tap = '0;
  logic [DW-1:0]     cmd_dwell = '0;
  logic              sample_in;
  logic [NCH-1:0]    ldcnt;
  logic [NCH*TW-1:0] dicnt;
  logic [NCH*TW-1:0] docnt;
  logic              busy, done, err, edge_found;
  logic [TW-1:0]     edge_tap;

  io_delay_tap_ctrl #(.NUM_CH(NCH), .TAP_W(TW), .DWELL_W(DW), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_tap(cmd_tap), .cmd_dwell(cmd_dwell),
    .sample_in(sample_in), .ldcnt(ldcnt), .dicnt(dicnt), .docnt(docnt),
    .busy(busy), .done(done), .err(err), .edge_found(edge_found), .edge_tap(edge_tap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             lat;
    bit             err;
    bit             ef;
    int             et;
    int             pulses;
    logic [NCH-1:0] mask;
    logic [NCH*TW-1:0] dic;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0, bad = 0, issued = 0, accepts = 0;
  int          thr = 99;
  bit          cor_en = 1'b0;
  int          cor_ch = 0;
  logic [TW-1:0] cor_val = '0;
  logic [TW-1:0] model_tap [NCH];

  // Channel model: loopback readback with an optional stuck channel; test signal high from tap thr up.
  always_comb begin
    docnt = dicnt;
    if (cor_en) docnt[cor_ch*TW +: TW] = cor_val;
    sample_in = (int'(dicnt[TW-1:0]) >= thr);
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic build_exp(input int op, input int ch, input int tap, input int dwell, output exp_t e);
    int d1, steps;
    d1 = (dwell == 0) ? 1 : dwell;
    e.err = 1'b0; e.ef = 1'b0; e.et = 0; e.pulses = 0; e.mask = '0; e.lat = 1;
    if (op == 3) begin
      e.err = 1'b1;
    end else if (op == 2) begin
      steps    = (thr <= 31) ? thr + 1 : 32;
      e.ef     = (thr <= 31);
      e.et     = (thr <= 31) ? thr : 0;
      e.pulses = steps;
      e.mask   = '1;
      e.lat    = steps * (2 + S + V + d1) + 1;
      for (int n = 0; n < NCH; n++) model_tap[n] = TW'(steps - 1);
    end else begin
      e.mask   = (op == 0) ? NCH'(1 << ch) : '1;
      e.pulses = 1;
      e.lat    = 2 + S + V;
      e.err    = (V == 1) && cor_en && e.mask[cor_ch] && (int'(cor_val) != tap);
      for (int n = 0; n < NCH; n++) if (e.mask[n]) model_tap[n] = TW'(tap);
    end
    e.dic = '0;
    for (int n = 0; n < NCH; n++) e.dic[n*TW +: TW] = model_tap[n];
  endtask

  task automatic issue(input int op, input int ch, input int tap, input int dwell, input bit hold, input bit push);
    exp_t e;
    int n;
    if (push) begin
      build_exp(op, ch, tap, dwell, e);
      sb_q.push_back(e);
    end
    cmd_op = 2'(op); cmd_ch = 2'(ch); cmd_tap = TW'(tap); cmd_dwell = DW'(dwell);
    cmd_valid = 1'b1;
    issued++;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 500);
    check("cmd_ready_seen", cmd_ready, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3000) begin @(posedge clk); #1; n++; end
    check("done_seen", done, 1);
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ldcnt"},      ldcnt, 0);
    check({tag, "_dicnt"},      dicnt, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_err"},        err, 0);
    check({tag, "_edge_found"}, edge_found, 0);
    check({tag, "_edge_tap"},   edge_tap, 0);
    check({tag, "_cmd_ready"},  cmd_ready, 1);
  endtask

  // Monitor: latency and ldcnt activity measured from the acceptance cycle.
  int             mon_cyc = 0, acc_cyc = 0, mon_pulses = 0;
  logic [NCH-1:0] mon_or = '0;
  exp_t           em;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (rst) begin
        mon_pulses = 0; mon_or = '0;
      end else begin
        if (ldcnt != '0) begin mon_pulses++; mon_or |= ldcnt; end
        if (done) begin
          if (sb_q.size() == 0) begin
            check("done_without_command", done, 0);
          end else begin
            em = sb_q.pop_front();
            check("latency",    mon_cyc - acc_cyc, em.lat);
            check("err",        err, em.err);
            check("edge_found", edge_found, em.ef);
            check("edge_tap",   edge_tap, em.et);
            check("ld_pulses",  mon_pulses, em.pulses);
            check("ld_mask",    mon_or, em.mask);
            check("dicnt",      dicnt, em.dic);
            check("busy_at_done", busy, 1);
          end
        end
        if (cmd_valid && cmd_ready) begin
          accepts++;
          acc_cyc = mon_cyc; mon_pulses = 0; mon_or = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int op, n;
    for (int i = 0; i < NCH; i++) model_tap[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // LOAD_ONE ch2 tap17 with loopback, cmd_valid held through the command
    issue(0, 2, 17, 0, 1'b1, 1'b1); wait_done();
    // LOAD_ALL tap9 with channel 3 reading back 8
    cor_en = 1'b1; cor_ch = 3; cor_val = 5'd8;
    issue(1, 0, 9, 0, 1'b0, 1'b1); wait_done();
    cor_en = 1'b0;
    // SWEEP dwell4, edge once tap >= 12
    thr = 12;
    issue(2, 0, 0, 4, 1'b0, 1'b1); wait_done();
    // SWEEP dwell0, no edge: full 32 steps
    thr = 99;
    issue(2, 0, 0, 0, 1'b0, 1'b1); wait_done();
    // reserved opcode with cmd_valid held
    issue(3, 1, 5, 0, 1'b1, 1'b1); wait_done();

    // reset in the middle of a sweep's dwell at tap 7
    thr = 99;
    issue(2, 0, 0, 30, 1'b0, 1'b0);
    n = 0;
    while (!(dicnt[TW-1:0] == 5'd7 && ldcnt == '0) && n < 2000) begin @(posedge clk); #1; n++; end
    check("sweep_reached_tap7", dicnt[TW-1:0], 7);
    repeat (S + V + 5) begin @(posedge clk); #1; end
    check("busy_before_reset", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midsweep_reset");
    for (int i = 0; i < NCH; i++) model_tap[i] = '0;
    @(posedge clk); #1 rst = 1'b0;
    issue(0, 1, 22, 0, 1'b0, 1'b1); wait_done();

    // randomized commands
    for (int k = 0; k < 14; k++) begin
      op     = $urandom_range(0, 3);
      thr    = $urandom_range(0, 40);
      cor_en = (op < 2) && ($urandom_range(0, 2) == 0);
      cor_ch = $urandom_range(0, 3);
      cor_val = TW'($urandom);
      issue(op, $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'b1);
      wait_done();
      cor_en = 1'b0;
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", sb_q.size(), 0);
    check("acceptances", accepts, issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
